// File: rtl/sd_sample_pacer.sv
// sd_sample_pacer: periodic sample-and-forward stage for the SD data path.
// The block arms on the first nonzero in_data seen while arm_en is high.
// After arming it captures in_data every PERIOD clocks into a
// first-word-fall-through FIFO. The FIFO drains on a valid/ready handshake,
// so downstream back-pressure never stalls the pacing counter. A capture
// that finds the FIFO full, with no pop in the same cycle, is dropped and
// counted.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_data      word to sample; a nonzero value also triggers arming
//   arm_en       enables arming on a nonzero in_data
//   clear        synchronous disarm, FIFO flush and drop-count reset
//   out_data     FIFO head word (0 when empty)
//   out_valid    FIFO holds at least one entry
//   out_ready    downstream accepts out_data this cycle
//   armed        block is in the ARMED state
//   tick         high during the cycle whose closing edge captures
//   fifo_level   number of entries held, 0..FIFO_DEPTH
//   overflow_cnt dropped captures, saturating at 255
module sd_sample_pacer #(
    parameter int DATA_W     = 8,
    parameter int PERIOD     = 96,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 17,
    parameter int LVL_W      = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              arm_en,
    input  logic              clear,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              armed,
    output logic              tick,
    output logic [LVL_W-1:0]  fifo_level,
    output logic [7:0]        overflow_cnt
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic {
        IDLE,
        ARMED
    } state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic              full, pop, push, drop;

    // ------------------------------------------------------------------
    // Pacing FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        armed      = (state == ARMED);
        tick       = (state == ARMED) && (cnt == CNT_LAST);

        if (clear) begin
            // clear dominates, including an arm request in the same cycle
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arm_en && (in_data != '0)) begin
                        state_next = ARMED;
                        cnt_next   = '0;
                    end
                end
                ARMED: begin
                    cnt_next = tick ? '0 : cnt + CNT_W'(1);
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Capture FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    always_comb begin
        out_valid = (fifo_level != '0);
        out_data  = out_valid ? mem[rd_ptr] : '0;
        full      = (fifo_level == LVL_FULL);
        pop       = out_valid && out_ready;
        // a full FIFO still accepts a capture when the head leaves in the same cycle
        push      = tick && !clear && (!full || pop);
        drop      = tick && !clear && full && !pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            fifo_level   <= '0;
            overflow_cnt <= '0;
        end else if (clear) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            fifo_level   <= '0;
            overflow_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
            if (drop && (overflow_cnt != 8'hFF)) begin
                overflow_cnt <= overflow_cnt + 8'd1;
            end
        end
    end

    // Storage is not reset; out_data is masked to 0 whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_sd_sample_pacer.sv
module tb_sd_sample_pacer;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       arm_en;
    logic       clear;
    logic       out_ready;

    // PERIOD=96 instance
    logic [7:0] a_out_data;
    logic       a_out_valid;
    logic       a_armed;
    logic       a_tick;
    logic [2:0] a_fifo_level;
    logic [7:0] a_overflow_cnt;

    // PERIOD=1 instance, shares the input stimulus
    logic [7:0] b_out_data;
    logic       b_out_valid;
    logic       b_armed;
    logic       b_tick;
    logic [2:0] b_fifo_level;
    logic [7:0] b_overflow_cnt;

    int vectors;
    int miscompares;

    sd_sample_pacer #(
        .DATA_W(8), .PERIOD(96), .FIFO_DEPTH(4), .CNT_W(17), .LVL_W(3)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .arm_en(arm_en),
        .clear(clear), .out_data(a_out_data), .out_valid(a_out_valid),
        .out_ready(out_ready), .armed(a_armed), .tick(a_tick),
        .fifo_level(a_fifo_level), .overflow_cnt(a_overflow_cnt)
    );

    sd_sample_pacer #(
        .DATA_W(8), .PERIOD(1), .FIFO_DEPTH(4), .CNT_W(17), .LVL_W(3)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .arm_en(arm_en),
        .clear(clear), .out_data(b_out_data), .out_valid(b_out_valid),
        .out_ready(out_ready), .armed(b_armed), .tick(b_tick),
        .fifo_level(b_fifo_level), .overflow_cnt(b_overflow_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [7:0] prev;
        vectors     = 0;
        miscompares = 0;
        rst_n     = 1'b0;
        in_data   = 8'h00;
        arm_en    = 1'b1;
        clear     = 1'b0;
        out_ready = 1'b0;

        // Reset state before any clock edge
        #2;
        check("rst_armed", a_armed, 0);
        check("rst_tick", a_tick, 0);
        check("rst_valid", a_out_valid, 0);
        check("rst_data", a_out_data, 0);
        check("rst_level", a_fifo_level, 0);
        check("rst_ovf", a_overflow_cnt, 0);
        step(3);
        rst_n = 1'b1;

        // 1: arm_en high with in_data zero never arms
        for (int i = 0; i < 200; i++) begin
            step(1);
            check("t1_armed", a_armed, 0);
            check("t1_tick", a_tick, 0);
        end
        check("t1_valid", a_out_valid, 0);
        check("t1_level", a_fifo_level, 0);

        // 2: arm on 0x5A, capture every 96 edges
        in_data   = 8'h5A;
        out_ready = 1'b1;
        step(1);                        // arm edge A
        check("t2_armed", a_armed, 1);
        check("t2_tick_A", a_tick, 0);
        check("t2_level_A", a_fifo_level, 0);
        step(94);                       // after A+94
        check("t2_tick_94", a_tick, 0);
        step(1);                        // after A+95
        check("t2_tick_95", a_tick, 1);
        step(1);                        // after A+96: captured
        check("t2_valid", a_out_valid, 1);
        check("t2_data", a_out_data, 8'h5A);
        check("t2_tick_96", a_tick, 0);
        step(1);
        check("t2_popped", a_out_valid, 0);
        step(94);                       // after A+191
        check("t2_tick_191", a_tick, 1);
        step(1);
        check("t2_valid2", a_out_valid, 1);
        check("t2_data2", a_out_data, 8'h5A);

        // clear; arming suppressed despite arm_en=1 and in_data nonzero
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check("clr_armed", a_armed, 0);
        check("clr_level", a_fifo_level, 0);

        // 3: six captures 1..6 with no drain -> four held, two dropped
        in_data   = 8'h01;
        out_ready = 1'b0;
        step(1);                        // arm edge A
        for (int k = 1; k <= 6; k++) begin
            step(96);
            in_data = 8'(k + 1);
            if (k == 4) begin
                check("t3_level4", a_fifo_level, 4);
                check("t3_ovf0", a_overflow_cnt, 0);
            end
        end
        check("t3_level", a_fifo_level, 4);
        check("t3_ovf", a_overflow_cnt, 2);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("t3_drain", a_out_data, 32'(i));
            step(1);
        end
        check("t3_empty_level", a_fifo_level, 0);
        check("t3_empty_valid", a_out_valid, 0);
        check("t3_empty_data", a_out_data, 0);
        out_ready = 1'b0;

        // 4: refill with 7..10, then pop exactly in a tick cycle
        for (int k = 7; k <= 10; k++) begin
            step((k == 7) ? 92 : 96);
            in_data = 8'(k + 1);
        end
        check("t4_level", a_fifo_level, 4);
        check("t4_ovf", a_overflow_cnt, 2);
        check("t4_hold", a_out_data, 8'h07);
        step(95);
        check("t4_tick", a_tick, 1);
        out_ready = 1'b1;
        step(1);                        // pop 7 and push 11 together
        check("t4_level_kept", a_fifo_level, 4);
        check("t4_ovf_kept", a_overflow_cnt, 2);
        for (int i = 8; i <= 11; i++) begin
            check("t4_order", a_out_data, 32'(i));
            step(1);
        end
        check("t4_empty", a_fifo_level, 0);
        out_ready = 1'b0;

        // 5: build level=2 / overflow=3, clear mid-period, re-arm
        for (int k = 0; k < 5; k++) begin
            step((k == 0) ? 92 : 96);
        end
        check("t5_full", a_fifo_level, 4);
        check("t5_ovf3", a_overflow_cnt, 3);
        out_ready = 1'b1;
        step(2);
        out_ready = 1'b0;
        check("t5_level2", a_fifo_level, 2);
        step(40);
        clear   = 1'b1;
        in_data = 8'h33;
        step(1);
        clear = 1'b0;
        check("t5_armed", a_armed, 0);
        check("t5_level", a_fifo_level, 0);
        check("t5_ovf", a_overflow_cnt, 0);
        check("t5_valid", a_out_valid, 0);
        check("t5_data", a_out_data, 0);
        step(1);                        // re-arm edge T
        check("t5_rearm", a_armed, 1);
        step(94);
        check("t5_tick_94", a_tick, 0);
        step(1);
        check("t5_tick_95", a_tick, 1);
        step(1);                        // T+96 is the first capture
        check("t5_cap_level", a_fifo_level, 1);
        check("t5_cap_data", a_out_data, 8'h33);

        // 6: asynchronous reset between edges
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_armed", a_armed, 0);
        check("t6_tick", a_tick, 0);
        check("t6_valid", a_out_valid, 0);
        check("t6_data", a_out_data, 0);
        check("t6_level", a_fifo_level, 0);
        check("t6_ovf", a_overflow_cnt, 0);
        check("t6_b_armed", b_armed, 0);
        check("t6_b_level", b_fifo_level, 0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        in_data   = 8'h20;
        out_ready = 1'b1;
        step(1);                        // arm edge for both instances
        check("t6_b_rearm", b_armed, 1);
        for (int i = 0; i < 8; i++) begin
            check("t6_b_tick", b_tick, 1);
            prev = in_data;
            step(1);
            check("t6_b_valid", b_out_valid, 1);
            check("t6_b_data", b_out_data, prev);
            check("t6_b_level", b_fifo_level, 1);
            in_data = prev + 8'd1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sd_sample_pacer.md
Name: sd_sample_pacer

Overview:
Parametrised periodic sample-and-forward block for the SD data path. It arms when a nonzero input word is seen, then captures the input word every PERIOD clocks. Captured words are buffered in a small FIFO and presented downstream on a valid/ready handshake, so back-pressure cannot stall the pacing counter. Dropped samples are counted and reported.

Parameters:
DATA_W, 8, width of sampled/forwarded word
PERIOD, 96, clocks between captures; legal range >= 1
FIFO_DEPTH, 4, capture buffer entries; power of 2, >= 2
CNT_W, 17, pacing counter width; must satisfy 2^CNT_W > PERIOD-1
LVL_W, 3, fifo_level width; equals clog2(FIFO_DEPTH)+1

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  reset, asynchronous, active-low
in_data  input  DATA_W  word to sample; also the arm trigger
arm_en  input  1  when high, a nonzero in_data arms the block
clear  input  1  synchronous disarm + flush
out_data  output  DATA_W  FIFO head word
out_valid  output  1  FIFO non-empty
out_ready  input  1  downstream accepts out_data
armed  output  1  high in ARMED state
tick  output  1  one-cycle pulse, high in the cycle a capture edge occurs
fifo_level  output  LVL_W  entries held, 0..FIFO_DEPTH
overflow_cnt  output  8  dropped captures, saturating at 255

Behaviour:
- Reset (rst_n low, async): state IDLE, counter 0, FIFO empty. armed=0, tick=0, out_valid=0, out_data=0, fifo_level=0, overflow_cnt=0. All outputs take these values immediately, without waiting for a clock edge.
- Two states, IDLE and ARMED.
  - IDLE -> ARMED at the edge where arm_en=1 and in_data!=0. Counter is loaded with 0 at that edge.
  - ARMED -> IDLE only on clear or reset.
  - arm_en going low while ARMED has no effect.
- ARMED counter:
  - Counter increments each clock.
  - When counter==PERIOD-1: tick=1 (combinational from state and counter), counter wraps to 0, and in_data is pushed at that edge.
  - If arming occurs at edge t, the first capture edge is t+PERIOD, then every PERIOD edges after.
  - With PERIOD=1, tick is high every ARMED cycle.
- FIFO:
  - First-word-fall-through. out_valid = (fifo_level!=0). out_data = head entry, read from registered storage, or 0 when empty.
  - A pop occurs when out_valid && out_ready at an edge.
  - While out_valid=1 and out_ready=0, out_data is held stable.
- Push/pop interaction:
  - Push and pop in the same cycle: both occur and the level is unchanged. This includes the full case: when full, a push coincident with a pop is accepted.
  - Push while full with no pop: the sample is dropped, the FIFO is untouched, and overflow_cnt increments (saturates at 255, no wrap).
  - Pop on empty is impossible because out_valid=0.
  - Read and write pointers wrap modulo FIFO_DEPTH. Order is strictly preserved.
- clear (synchronous, highest priority):
  - At the edge: state IDLE, counter 0, FIFO flushed, overflow_cnt=0.
  - A handshake completing in the clear cycle counts as delivered.
  - A tick in the clear cycle is still asserted but its push is discarded.
  - Arming is suppressed in the clear cycle. Re-arm is possible from the following cycle.
- No combinational path from in_data or out_ready to any output except tick's dependency on state and counter.

Test Plan:
1. Reset, arm_en=1, in_data=0 for 200 clks -> armed=0, tick never high, out_valid=0, fifo_level=0.
2. PERIOD=96, out_ready=1, in_data=8'h5A from edge 10 -> armed=1 after edge 10; tick in cycle before edge 106 and every 96 after; out_valid=1 with out_data=8'h5A for one cycle after each capture.
3. FIFO_DEPTH=4, out_ready=0, in_data incrementing 1,2,3,... per capture, 6 captures -> fifo_level=4, overflow_cnt=2; then out_ready=1 drains exactly 1,2,3,4 in order, level returns to 0.
4. FIFO full, out_ready pulsed high exactly in a tick cycle -> overflow_cnt unchanged, fifo_level stays 4, new word appears at the tail.
5. clear asserted mid-period with 2 entries buffered and overflow_cnt=3 -> next cycle armed=0, fifo_level=0, overflow_cnt=0; re-arm at edge T gives first tick exactly at edge T+PERIOD.
6. rst_n dropped asynchronously between edges while ARMED with data buffered -> all outputs zero before next clk edge. With PERIOD=1, after re-arm: tick continuous, one capture per cycle.
